dcache_write_buffer: RTL and testbench
======================================

Name: dcache_write_buffer

Overview:
- Block-granular write-back buffer sitting directly downstream of the per-CPU dcache.
- Accepts evicted or flushed dirty blocks (two 32-bit words each) and drains them to the memory/bus side one word at a time.
- Forwards buffered data to the dcache on address match, so a miss can refill from it.
- Produces the buffer_empty signal the dcache uses to qualify flushed at halt.

Parameters:
- DEPTH, 4, number of block entries; power of two, >=2.
- CPUID, 0, index used on the ccif-side memory signals.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- push_valid  in  1  dcache offers a dirty block this cycle.
- push_ready  out  1  buffer can accept; a push is taken when push_valid & push_ready at the clock edge.
- push_addr  in  32  block address; bits [2:0] ignored.
- push_data0  in  32  word at block offset 0 (addr bit 2 = 0).
- push_data1  in  32  word at block offset 1 (addr bit 2 = 1).
- mem_wen  out  1  memory write request.
- mem_addr  out  32  word address {blk[31:3], sel, 2'b00}.
- mem_store  out  32  word being written.
- mem_wait  in  1  memory busy; a word completes on a cycle where mem_wen & ~mem_wait.
- lookup_addr  in  32  dcache miss address.
- lookup_hit  out  1  lookup_addr[31:3] matches a valid entry.
- lookup_data  out  32  matching word, selected by lookup_addr[2].
- buffer_empty  out  1  no valid entries and drain FSM in IDLE.
- count  out  $clog2(DEPTH+1)  valid entry count.

Behaviour:
- Storage is a circular FIFO: head/tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH. count is held in a separate register.
- push_ready = (count != DEPTH). This is combinational and ignores a same-cycle retire; there is no full bypass.
- Push: writes {addr[31:3], data0, data1} at tail, then tail+1 and count+1.
- Drain FSM states: IDLE, W0, W1.
  - IDLE: if count != 0, go to W0 next cycle; mem_wen = 0.
  - W0: mem_wen = 1, mem_addr = {head.blk, 1'b0, 2'b00}, mem_store = head.data0. Stay while mem_wait; on ~mem_wait go to W1.
  - W1: same with sel = 1 and data1. On ~mem_wait, retire head (head+1, count-1) and go to IDLE.
  - IDLE always costs one bubble cycle between blocks.
- Minimum drain latency is 3 cycles per block: IDLE, W0, W1 with zero wait states.
- Simultaneous push and retire: count is unchanged, both pointers advance.
- Outputs are stable while mem_wait is high: mem_addr and mem_store do not change.
- Lookup is combinational and covers all valid entries, including the head while it drains (the head stays valid until the W1 retire edge).
  - Multiple matches cannot occur when coalescing is on. Without coalescing, the youngest entry (closest to tail) wins.
  - No match: lookup_hit = 0, lookup_data = 32'hBAD1BAD1.
- A push whose block matches the entry being retired in the same cycle is allocated normally.
- Reset values: head = tail = count = 0, all entry valid bits 0, FSM IDLE, mem_wen = 0, mem_addr = 0, mem_store = 0, buffer_empty = 1, lookup_hit = 0, push_ready = 1.
- Reset mid-drain: on the next edge all entries are discarded and mem_wen = 0. A partially written block is not completed.
- Entry data is not cleared on retire; only the valid bit is.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - A push whose block matches a valid entry that is not the draining head overwrites that entry's data in place. No allocation, count unchanged.
  - push_ready is also 1 when full and such a match exists.
  - A match against the head while the FSM is in W0 or W1 allocates a new entry instead.
- Undefined: every push allocates; push_ready = (count != DEPTH) only.

Test Plan:
- Push blk 0x0000_1000 with data0 = 0x11, data1 = 0x22, mem_wait = 0. Required: W0 writes 0x1000/0x11, next cycle W1 writes 0x1004/0x22; count returns 1->0; buffer_empty rises the cycle after retire.
- Push 4 blocks back-to-back with mem_wait = 1. Required: count = 4, push_ready = 0; a 5th push is held until the first retire; FIFO order is preserved on drain.
- With entry 0x2000 buffered and W0 stalled by mem_wait: lookup 0x2004 -> hit = 1, data = data1; lookup 0x3000 -> hit = 0, data = 0xBAD1BAD1.
- Simultaneous push and W1 retire at count = 2. Required: count stays 2, tail and head both advance, no lost entry.
- Assert RST during W1 with 3 entries. Required: next cycle mem_wen = 0, count = 0, buffer_empty = 1; a subsequent push drains normally.
- WB_COALESCE_EN: push 0x4000 (A, B), then 0x5000, then 0x4000 (C, D) while draining 0x5000-ordered entries. Required: count does not increase on the third push; 0x4000 drains C/D; without the macro, both copies drain in order.

Source files
------------

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: block-granular write-back FIFO between the dcache and memory.
// Define WB_COALESCE_EN to merge pushes into already-buffered, non-draining blocks.
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CPUID = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [31:0]                push_addr,
    input  logic [31:0]                push_data0,
    input  logic [31:0]                push_data1,
    output logic                       mem_wen,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_store,
    input  logic                       mem_wait,
    input  logic [31:0]                lookup_addr,
    output logic                       lookup_hit,
    output logic [31:0]                lookup_data,
    output logic                       buffer_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CPUID < 0)) begin : g_bad_params
    end

    typedef enum logic [1:0] {IDLE, W0, W1} state_t;
    state_t state, state_nx;

    logic [28:0]      ent_blk   [DEPTH];
    logic [31:0]      ent_d0    [DEPTH];
    logic [31:0]      ent_d1    [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]    head, tail;
    logic [PW-1:0]    look_idx;
    logic             push_fire, alloc, retire, coal_hit;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{push_addr[2:0], lookup_addr[1:0]};

`ifdef WB_COALESCE_EN
    logic [PW-1:0] coal_idx;

    // The head is off limits once its words start going out, so a drained block never changes mid-write.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_blk[i] == push_addr[31:3]) &&
                !((PW'(i) == head) && (state != IDLE))) begin
                coal_hit = 1'b1;
                coal_idx = PW'(i);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    assign push_ready   = (count != FULL) || coal_hit;
    assign push_fire    = push_valid & push_ready;
    assign alloc        = push_fire & ~coal_hit;
    assign retire       = (state == W1) & ~mem_wait;
    assign buffer_empty = (count == '0) && (state == IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (retire) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (alloc) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            count <= count + CW'(alloc) - CW'(retire);
        end
    end

    // Entry payload is never cleared; the valid bit alone decides visibility.
    always_ff @(posedge CLK) begin
        if (alloc) begin
            ent_blk[tail] <= push_addr[31:3];
            ent_d0[tail]  <= push_data0;
            ent_d1[tail]  <= push_data1;
        end
`ifdef WB_COALESCE_EN
        else if (push_fire) begin
            ent_d0[coal_idx] <= push_data0;
            ent_d1[coal_idx] <= push_data1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_store = '0;
        case (state)
            IDLE: if (count != '0) state_nx = W0;
            W0: begin
                mem_wen   = 1'b1;
                mem_addr  = {ent_blk[head], 3'b000};
                mem_store = ent_d0[head];
                if (!mem_wait) state_nx = W1;
            end
            W1: begin
                mem_wen   = 1'b1;
                mem_addr  = {ent_blk[head], 3'b100};
                mem_store = ent_d1[head];
                if (!mem_wait) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Valid entries are contiguous from head, so scanning oldest-to-youngest lets the youngest win.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = 32'hBAD1BAD1;
        look_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            look_idx = head + PW'(k);
            if (ent_valid[look_idx] && (ent_blk[look_idx] == lookup_addr[31:3])) begin
                lookup_hit  = 1'b1;
                lookup_data = lookup_addr[2] ? ent_d1[look_idx] : ent_d0[look_idx];
            end
        end
    end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_dcache_write_buffer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST;
    logic          push_valid;
    logic          push_ready;
    logic [31:0]   push_addr, push_data0, push_data1;
    logic          mem_wen;
    logic [31:0]   mem_addr, mem_store;
    logic          mem_wait;
    logic [31:0]   lookup_addr;
    logic          lookup_hit;
    logic [31:0]   lookup_data;
    logic          buffer_empty;
    logic [CW-1:0] count;

    dcache_write_buffer #(.DEPTH(DEPTH), .CPUID(0)) dut (
        .CLK(CLK), .RST(RST),
        .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
        .push_data0(push_data0), .push_data1(push_data1),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_store(mem_store), .mem_wait(mem_wait),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .buffer_empty(buffer_empty), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [28:0] blk; logic [31:0] d0; logic [31:0] d1; } ent_t;
    ent_t        q[$];
    int          phase;          // 0 idle, 1 writing word 0, 2 writing word 1
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        e_wen, e_ready, e_hit, e_empty;
    logic [31:0] e_addr, e_store, e_ldata;
    int          e_count;
    bit          last_acc;
    logic [63:0] obs_w[$];
    logic [63:0] exp_w[$];

`ifdef WB_COALESCE_EN
    function automatic int coal_j(logic [28:0] blk);
        int j = -1;
        for (int i = 0; i < q.size(); i++)
            if (q[i].blk == blk && !(i == 0 && phase != 0)) j = i;
        return j;
    endfunction
`endif

    task automatic calc();
        e_wen   = (phase != 0);
        e_addr  = 32'h0;
        e_store = 32'h0;
        if (phase == 1) begin e_addr = {q[0].blk, 3'b000}; e_store = q[0].d0; end
        if (phase == 2) begin e_addr = {q[0].blk, 3'b100}; e_store = q[0].d1; end
        e_count = q.size();
        e_empty = (q.size() == 0) && (phase == 0);
        e_ready = (q.size() != DEPTH);
`ifdef WB_COALESCE_EN
        if (coal_j(push_addr[31:3]) >= 0) e_ready = 1'b1;
`endif
        e_hit   = 1'b0;
        e_ldata = 32'hBAD1BAD1;
        for (int j = q.size() - 1; j >= 0; j--) begin
            if (q[j].blk == lookup_addr[31:3]) begin
                e_hit   = 1'b1;
                e_ldata = lookup_addr[2] ? q[j].d1 : q[j].d0;
                break;
            end
        end
    endtask

    task automatic step();
        int sz;
        int j;
        bit ret;
        sz = q.size();
        j  = -1;
        last_acc = push_valid && e_ready && !RST;
        if (RST) begin
            q.delete();
            phase = 0;
        end else begin
            ret = (phase == 2) && !mem_wait;
`ifdef WB_COALESCE_EN
            j = coal_j(push_addr[31:3]);
`endif
            if (last_acc && j >= 0) begin q[j].d0 = push_data0; q[j].d1 = push_data1; end
            if (ret) void'(q.pop_front());
            if (last_acc && j < 0) q.push_back('{push_addr[31:3], push_data0, push_data1});
            if (phase == 0)      phase = (sz != 0) ? 1 : 0;
            else if (phase == 1) phase = mem_wait ? 1 : 2;
            else                 phase = mem_wait ? 2 : 0;
        end
    endtask

    task automatic setin(input logic pv, input logic [31:0] pa, input logic [31:0] d0,
                         input logic [31:0] d1, input logic mw, input logic [31:0] la,
                         input logic rst);
        push_valid = pv; push_addr = pa; push_data0 = d0; push_data1 = d1;
        mem_wait = mw; lookup_addr = la; RST = rst;
        #1;
        calc();
    endtask

    task automatic adv();
        if (!RST && mem_wen && !mem_wait) obs_w.push_back({mem_addr, mem_store});
        @(posedge CLK);
        step();
        @(negedge CLK);
    endtask

    task automatic expect_blk(input logic [28:0] blk, input logic [31:0] d0, input logic [31:0] d1);
        exp_w.push_back({blk, 3'b000, d0});
        exp_w.push_back({blk, 3'b100, d1});
    endtask

    task automatic test_reset();
        setin(1'b1, $urandom, $urandom, $urandom, 1'b0, 32'h0, 1'b1);
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h1000, 1'b0);
        n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL rst_wen got %b want 0", mem_wen); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_store !== 32'h0) begin n_bad++; $display("FAIL rst_store got %h want 0", mem_store); end
        n_cmp++; if (buffer_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b want 1", buffer_empty); end
        n_cmp++; if (lookup_hit !== 1'b0) begin n_bad++; $display("FAIL rst_hit got %b want 0", lookup_hit); end
        n_cmp++; if (lookup_data !== 32'hBAD1BAD1) begin n_bad++; $display("FAIL rst_ldata got %h want bad1bad1", lookup_data); end
        n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", push_ready); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_count got %0d want 0", count); end
    endtask

    task automatic test_single();
        setin(1'b1, 32'h0000_1005, 32'h11, 32'h22, 1'b0, 32'h1000, 1'b0);
        n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL one_ready got %b want 1", push_ready); end
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h1000, 1'b0);
        n_cmp++; if (count !== 3'd1 || mem_wen !== 1'b0) begin n_bad++; $display("FAIL one_idle count %0d wen %b want 1/0", count, mem_wen); end
        n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h11) begin n_bad++; $display("FAIL one_lookup got %b/%h want 1/11", lookup_hit, lookup_data); end
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h1000, 1'b0);
        n_cmp++; if (mem_wen !== 1'b1 || mem_addr !== 32'h1000 || mem_store !== 32'h11) begin n_bad++; $display("FAIL one_w0 got %b %h %h want 1 1000 11", mem_wen, mem_addr, mem_store); end
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h1000, 1'b0);
        n_cmp++; if (mem_wen !== 1'b1 || mem_addr !== 32'h1004 || mem_store !== 32'h22 || count !== 3'd1) begin n_bad++; $display("FAIL one_w1 got %b %h %h c%0d want 1 1004 22 c1", mem_wen, mem_addr, mem_store, count); end
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h1000, 1'b0);
        n_cmp++; if (count !== 3'd0 || buffer_empty !== 1'b1 || mem_wen !== 1'b0) begin n_bad++; $display("FAIL one_done count %0d empty %b wen %b want 0/1/0", count, buffer_empty, mem_wen); end
    endtask

    task automatic test_full();
        logic [28:0] base;
        logic [31:0] d0 [5];
        logic [31:0] d1 [5];
        bool_pend: begin end
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        adv();
        obs_w.delete(); exp_w.delete();
        base = 29'($urandom_range(0, 32'h00FF_FFFF));
        for (int i = 0; i < 5; i++) begin d0[i] = $urandom; d1[i] = $urandom; expect_blk(base + 29'(i), d0[i], d1[i]); end
        for (int i = 0; i < 4; i++) begin
            setin(1'b1, {base + 29'(i), 3'b000}, d0[i], d1[i], 1'b1, 32'h0, 1'b0);
            n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL full_fill%0d ready got %b want 1", i, push_ready); end
            adv();
        end
        for (int c = 0; c < 3; c++) begin
            setin(1'b1, {base + 29'd4, 3'b000}, d0[4], d1[4], 1'b1, 32'h0, 1'b0);
            n_cmp++; if (count !== 3'd4 || push_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold count %0d ready %b want 4/0", count, push_ready); end
            n_cmp++; if (mem_addr !== {base, 3'b000}) begin n_bad++; $display("FAIL full_stable addr %h want %h", mem_addr, {base, 3'b000}); end
            adv();
        end
        last_acc = 1'b0;
        begin
            bit pend = 1'b1;
            int c = 0;
            while (c < 60 && (pend || q.size() != 0 || phase != 0)) begin
                setin(pend, {base + 29'd4, 3'b000}, d0[4], d1[4], 1'b0, 32'h0, 1'b0);
                n_cmp++; if (push_ready !== e_ready || count !== CW'(e_count)) begin n_bad++; $display("FAIL full_drain ready %b count %0d want %b/%0d", push_ready, count, e_ready, e_count); end
                adv();
                if (last_acc) pend = 1'b0;
                c++;
            end
            n_cmp++; if (pend || q.size() != 0) begin n_bad++; $display("FAIL full_timeout pending %b left %0d want 0/0", pend, q.size()); end
        end
        n_cmp++; if (obs_w.size() != exp_w.size()) begin n_bad++; $display("FAIL full_nwords got %0d want %0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            n_cmp++; if (obs_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL full_order[%0d] got %h want %h", i, obs_w[i], exp_w[i]); end
        end
    endtask

    task automatic test_lookup();
        logic [31:0] a0, a1;
        a0 = $urandom; a1 = $urandom;
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        adv();
        setin(1'b1, 32'h2000, a0, a1, 1'b1, 32'h0, 1'b0); adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0); adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h2004, 1'b0);
        n_cmp++; if (mem_wen !== 1'b1 || mem_addr !== 32'h2000) begin n_bad++; $display("FAIL lk_w0 got %b %h want 1 2000", mem_wen, mem_addr); end
        n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== a1) begin n_bad++; $display("FAIL lk_word1 got %b/%h want 1/%h", lookup_hit, lookup_data, a1); end
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h2000, 1'b0);
        n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== a0) begin n_bad++; $display("FAIL lk_word0 got %b/%h want 1/%h", lookup_hit, lookup_data, a0); end
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h3000, 1'b0);
        n_cmp++; if (lookup_hit !== 1'b0 || lookup_data !== 32'hBAD1BAD1) begin n_bad++; $display("FAIL lk_miss got %b/%h want 0/bad1bad1", lookup_hit, lookup_data); end
        for (int c = 0; c < 10; c++) begin setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0); adv(); end
    endtask

    task automatic test_push_retire();
        logic [31:0] d [6];
        bit found;
        for (int i = 0; i < 6; i++) d[i] = $urandom;
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        adv();
        obs_w.delete(); exp_w.delete();
        expect_blk(29'h0A00, d[0], d[1]); expect_blk(29'h0A01, d[2], d[3]); expect_blk(29'h0A02, d[4], d[5]);
        setin(1'b1, {29'h0A00, 3'b000}, d[0], d[1], 1'b0, 32'h0, 1'b0); adv();
        setin(1'b1, {29'h0A01, 3'b000}, d[2], d[3], 1'b0, 32'h0, 1'b0); adv();
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            if (phase == 2 && q.size() == 2) found = 1'b1;
            else adv();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL pr_reach_w1 got 0 want 1"); end
        setin(1'b1, {29'h0A02, 3'b000}, d[4], d[5], 1'b0, 32'h0, 1'b0);
        n_cmp++; if (count !== 3'd2 || mem_addr !== {29'h0A00, 3'b100}) begin n_bad++; $display("FAIL pr_before count %0d addr %h want 2 %h", count, mem_addr, {29'h0A00, 3'b100}); end
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL pr_after count got %0d want 2", count); end
        for (int c = 0; c < 20 && (q.size() != 0 || phase != 0); c++) begin setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0); adv(); end
        n_cmp++; if (obs_w.size() != exp_w.size()) begin n_bad++; $display("FAIL pr_nwords got %0d want %0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            n_cmp++; if (obs_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL pr_order[%0d] got %h want %h", i, obs_w[i], exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        logic [31:0] n0, n1;
        n0 = $urandom; n1 = $urandom;
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        adv();
        for (int i = 0; i < 3; i++) begin setin(1'b1, {29'h0B00 + 29'(i), 3'b000}, $urandom, $urandom, 1'b1, 32'h0, 1'b0); adv(); end
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
            if (phase == 2) found = 1'b1;
            else adv();
        end
        n_cmp++; if (!found || count !== 3'd3) begin n_bad++; $display("FAIL rm_reach_w1 found %b count %0d want 1/3", found, count); end
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, {29'h0B00, 3'b000}, 1'b0);
        n_cmp++; if (mem_wen !== 1'b0 || count !== 3'd0 || buffer_empty !== 1'b1) begin n_bad++; $display("FAIL rm_after wen %b count %0d empty %b want 0/0/1", mem_wen, count, buffer_empty); end
        n_cmp++; if (lookup_hit !== 1'b0) begin n_bad++; $display("FAIL rm_lookup got %b want 0", lookup_hit); end
        obs_w.delete(); exp_w.delete();
        expect_blk(29'h0C00, n0, n1);
        setin(1'b1, {29'h0C00, 3'b000}, n0, n1, 1'b0, 32'h0, 1'b0); adv();
        for (int c = 0; c < 10 && (q.size() != 0 || phase != 0); c++) begin setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0); adv(); end
        n_cmp++; if (obs_w.size() != 2 || obs_w[0] !== exp_w[0] || obs_w[1] !== exp_w[1]) begin n_bad++; $display("FAIL rm_redrain got %0d words want %h %h", obs_w.size(), exp_w[0], exp_w[1]); end
    endtask

    task automatic test_coalesce();
        logic [31:0] d [8];
        logic [2:0]  want_cnt;
        for (int i = 0; i < 8; i++) d[i] = $urandom;
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        adv();
        obs_w.delete(); exp_w.delete();
        setin(1'b1, 32'h6000, d[0], d[1], 1'b1, 32'h0, 1'b0); adv();
        setin(1'b1, 32'h4000, d[2], d[3], 1'b1, 32'h0, 1'b0); adv();
        setin(1'b1, 32'h5000, d[4], d[5], 1'b1, 32'h0, 1'b0); adv();
        setin(1'b1, 32'h4000, d[6], d[7], 1'b1, 32'h4004, 1'b0);
        n_cmp++; if (count !== 3'd3 || mem_addr !== 32'h6000) begin n_bad++; $display("FAIL co_before count %0d addr %h want 3 6000", count, mem_addr); end
        adv();
        setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h4004, 1'b0);
        expect_blk(29'h0C00, d[0], d[1]);
`ifdef WB_COALESCE_EN
        want_cnt = 3'd3;
        expect_blk(29'h0800, d[6], d[7]); expect_blk(29'h0A00, d[4], d[5]);
`else
        want_cnt = 3'd4;
        expect_blk(29'h0800, d[2], d[3]); expect_blk(29'h0A00, d[4], d[5]); expect_blk(29'h0800, d[6], d[7]);
`endif
        n_cmp++; if (count !== want_cnt) begin n_bad++; $display("FAIL co_count got %0d want %0d", count, want_cnt); end
        n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== d[7]) begin n_bad++; $display("FAIL co_lookup got %b/%h want 1/%h", lookup_hit, lookup_data, d[7]); end
        for (int c = 0; c < 30 && (q.size() != 0 || phase != 0); c++) begin setin(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0); adv(); end
        n_cmp++; if (obs_w.size() != exp_w.size()) begin n_bad++; $display("FAIL co_nwords got %0d want %0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            n_cmp++; if (obs_w[i] !== exp_w[i]) begin n_bad++; $display("FAIL co_order[%0d] got %h want %h", i, obs_w[i], exp_w[i]); end
        end
    endtask

    task automatic test_random();
        logic [28:0] pool [6];
        for (int i = 0; i < 6; i++) pool[i] = 29'h1000 + 29'(i);
        for (int c = 0; c < 800; c++) begin
            setin(1'($urandom_range(0, 1)),
                  {pool[$urandom_range(0, 5)], 3'($urandom)}, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0),
                  {pool[$urandom_range(0, 5)], 3'($urandom)},
                  ($urandom_range(0, 99) == 0));
            n_cmp++; if (mem_wen !== e_wen) begin n_bad++; $display("FAIL rnd_wen c%0d got %b want %b", c, mem_wen, e_wen); end
            n_cmp++; if (mem_addr !== e_addr) begin n_bad++; $display("FAIL rnd_addr c%0d got %h want %h", c, mem_addr, e_addr); end
            n_cmp++; if (mem_store !== e_store) begin n_bad++; $display("FAIL rnd_store c%0d got %h want %h", c, mem_store, e_store); end
            n_cmp++; if (push_ready !== e_ready) begin n_bad++; $display("FAIL rnd_ready c%0d got %b want %b", c, push_ready, e_ready); end
            n_cmp++; if (count !== CW'(e_count)) begin n_bad++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count, e_count); end
            n_cmp++; if (buffer_empty !== e_empty) begin n_bad++; $display("FAIL rnd_empty c%0d got %b want %b", c, buffer_empty, e_empty); end
            n_cmp++; if (lookup_hit !== e_hit) begin n_bad++; $display("FAIL rnd_hit c%0d got %b want %b", c, lookup_hit, e_hit); end
            n_cmp++; if (lookup_data !== e_ldata) begin n_bad++; $display("FAIL rnd_ldata c%0d got %h want %h", c, lookup_data, e_ldata); end
            adv();
        end
    endtask

    initial begin
        phase = 0;
        RST = 1'b1; push_valid = 1'b0; push_addr = '0; push_data0 = '0; push_data1 = '0;
        mem_wait = 1'b0; lookup_addr = '0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_full();
        test_lookup();
        test_push_retire();
        test_reset_mid();
        test_coalesce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
